// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: architectural register file with a per-register
// pending-write scoreboard for RAW hazard detection at the read stage.
//
// Optional feature macro: REGFILE_FORWARD_EN
//   defined   -> same-cycle write-through on both read ports; hazard is
//                suppressed for a register whose last pending write lands now
//   undefined -> reads return the pre-write value; hazard clears only once
//                the pending counter has reached zero
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   wb_destination        write-back destination, MSB set = no write
//   wb_result             write-back data
//   wb_backpressure       1 = write-back flowing, 0 = write-back stalled
//   rd_addr0/1            read addresses
//   rd_data0/1            registered read data (1-cycle latency)
//   issue_valid/dest      read stage issues a write to issue_dest
//   issue_ready           pending counter of issue_dest can accept an issue
//   flush                 synchronous clear of all pending counters
//   hazard                a read address has an unresolved pending write
//   stall                 hazard or stalled write-back
module regfile_scoreboard #(
  parameter int unsigned D_SIZE     = 32,
  parameter int unsigned REG_A_SIZE = 3,
  parameter int unsigned PEND_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_A_SIZE:0]   wb_destination,
  input  logic [D_SIZE-1:0]     wb_result,
  input  logic                  wb_backpressure,
  input  logic [REG_A_SIZE-1:0] rd_addr0,
  input  logic [REG_A_SIZE-1:0] rd_addr1,
  output logic [D_SIZE-1:0]     rd_data0,
  output logic [D_SIZE-1:0]     rd_data1,
  input  logic                  issue_valid,
  input  logic [REG_A_SIZE-1:0] issue_dest,
  output logic                  issue_ready,
  input  logic                  flush,
  output logic                  hazard,
  output logic                  stall
);

  localparam int unsigned NREG = 2 ** REG_A_SIZE;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

`ifdef REGFILE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic [D_SIZE-1:0]     regs    [NREG];
  logic [PEND_W-1:0]     pending [NREG];
  logic [NREG-1:0]       inc_vec;
  logic [NREG-1:0]       dec_vec;
  logic                  wr_en;
  logic [REG_A_SIZE-1:0] wr_addr;
  logic                  hz0;
  logic                  hz1;

  assign wr_en   = ~wb_destination[REG_A_SIZE];
  assign wr_addr = wb_destination[REG_A_SIZE-1:0];

  // Decrement: a landing write retires one tracked in-flight destination
  always_comb begin
    dec_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      dec_vec[i] = wr_en && (wr_addr == REG_A_SIZE'(i)) && (pending[i] != '0);
    end
  end

  // A saturated counter still accepts an issue if it is retiring one now
  assign issue_ready = !((pending[issue_dest] == PEND_MAX) && !dec_vec[issue_dest]);

  // Increment: accepted issue to this destination
  always_comb begin
    inc_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      inc_vec[i] = issue_valid && issue_ready && (issue_dest == REG_A_SIZE'(i));
    end
  end

  // Per-port hazard, bypassed only when the last pending write lands now
  always_comb begin
    hz0 = (pending[rd_addr0] != '0) &&
          !(FWD && (pending[rd_addr0] == PEND_ONE) && wr_en && (wr_addr == rd_addr0));
    hz1 = (pending[rd_addr1] != '0) &&
          !(FWD && (pending[rd_addr1] == PEND_ONE) && wr_en && (wr_addr == rd_addr1));
  end

  assign hazard = hz0 | hz1;
  assign stall  = hazard | ~wb_backpressure;

  // Pending counters; flush overrides any same-cycle inc/dec
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) pending[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) pending[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          pending[i] <= pending[i] + PEND_ONE;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          pending[i] <= pending[i] - PEND_ONE;
        end
      end
    end
  end

  // Register file storage; writes are never refused
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wb_result;
    end
  end

  // Registered read ports with optional write-through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data0 <= '0;
      rd_data1 <= '0;
    end else begin
      rd_data0 <= (FWD && wr_en && (wr_addr == rd_addr0)) ? wb_result : regs[rd_addr0];
      rd_data1 <= (FWD && wr_en && (wr_addr == rd_addr1)) ? wb_result : regs[rd_addr1];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
// Inputs change on the falling edge; combinational outputs are sampled 1ns
// later, registered outputs 1ns after the rising edge.
module tb_regfile_scoreboard;

`ifdef REGFILE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wb_destination;
  logic [31:0] wb_result;
  logic        wb_backpressure;
  logic [2:0]  rd_addr0;
  logic [2:0]  rd_addr1;
  logic [31:0] rd_data0;
  logic [31:0] rd_data1;
  logic        issue_valid;
  logic [2:0]  issue_dest;
  logic        issue_ready;
  logic        flush;
  logic        hazard;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  regfile_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .wb_destination  (wb_destination),
    .wb_result       (wb_result),
    .wb_backpressure (wb_backpressure),
    .rd_addr0        (rd_addr0),
    .rd_addr1        (rd_addr1),
    .rd_data0        (rd_data0),
    .rd_data1        (rd_data1),
    .issue_valid     (issue_valid),
    .issue_dest      (issue_dest),
    .issue_ready     (issue_ready),
    .flush           (flush),
    .hazard          (hazard),
    .stall           (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Idle inputs: no write, no issue, no flush, write-back flowing
  task automatic idle();
    wb_destination  = 4'b1000;
    wb_result       = 32'h0;
    wb_backpressure = 1'b1;
    issue_valid     = 1'b0;
    issue_dest      = 3'd0;
    flush           = 1'b0;
    rd_addr0        = 3'd0;
    rd_addr1        = 3'd7;
  endtask

  task automatic wr(input logic [3:0] d, input logic [31:0] v);
    wb_destination = d;
    wb_result      = v;
  endtask

  task automatic iss(input logic [2:0] d);
    issue_valid = 1'b1;
    issue_dest  = d;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    chk("reset_rd_data0", rd_data0, 32'h0);
    chk("reset_hazard", {31'h0, hazard}, 32'h0);
    chk("reset_issue_ready", {31'h0, issue_ready}, 32'h1);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Write reg3 and give it a pending write, then reset mid-run
    @(negedge clk); idle(); wr(4'd3, 32'hDEAD); iss(3'd3);
    post();
    @(negedge clk); idle(); rd_addr0 = 3'd3;
    #1;
    chk("pre_reset_hazard3", {31'h0, hazard}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_rd_data0", rd_data0, 32'h0);
    chk("midrst_hazard", {31'h0, hazard}, 32'h0);
    issue_dest = 3'd3;
    #1;
    chk("midrst_issue_ready", {31'h0, issue_ready}, 32'h1);
    @(negedge clk); rst = 1'b0; idle(); rd_addr0 = 3'd3;
    #1;
    chk("postrst_hazard3", {31'h0, hazard}, 32'h0);
    post();
    chk("postrst_rd3", rd_data0, 32'h0);

    // Write reg5 then read it on port 1
    @(negedge clk); idle(); wr(4'd5, 32'h1234);
    post();
    @(negedge clk); idle(); rd_addr1 = 3'd5;
    post();
    chk("rd1_reg5", rd_data1, 32'h1234);

    // Out-of-bound destination (MSB set, low bits 0) writes nothing
    @(negedge clk); idle(); wr(4'd8, 32'hFFFF_FFFF);
    post();
    @(negedge clk); idle(); rd_addr0 = 3'd0; rd_addr1 = 3'd5;
    post();
    chk("oob_reg0", rd_data0, 32'h0);
    chk("oob_reg5", rd_data1, 32'h1234);

    // Register 0 is an ordinary register
    @(negedge clk); idle(); wr(4'd0, 32'h5A);
    post();
    @(negedge clk); idle(); rd_addr0 = 3'd0;
    post();
    chk("reg0_write", rd_data0, 32'h5A);

    // RAW hazard on reg2
    @(negedge clk); idle(); iss(3'd2);
    #1;
    chk("iss2_ready", {31'h0, issue_ready}, 32'h1);
    post();
    @(negedge clk); idle(); rd_addr0 = 3'd2;
    #1;
    chk("raw2_hazard", {31'h0, hazard}, 32'h1);
    chk("raw2_stall", {31'h0, stall}, 32'h1);
    @(negedge clk); idle(); rd_addr0 = 3'd2; wr(4'd2, 32'hAA);
    #1;
    chk("wb2_hazard", {31'h0, hazard}, FWD ? 32'h0 : 32'h1);
    post();
    chk("wb2_rd_data0", rd_data0, FWD ? 32'hAA : 32'h0);
    @(negedge clk); idle(); rd_addr0 = 3'd2;
    #1;
    chk("after2_hazard", {31'h0, hazard}, 32'h0);
    post();
    chk("after2_rd_data0", rd_data0, 32'hAA);

    // Saturate reg4 counter at 3
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle(); iss(3'd4);
      #1;
      chk($sformatf("iss4_ready_%0d", k), {31'h0, issue_ready}, 32'h1);
      post();
    end
    @(negedge clk); idle(); iss(3'd4);
    #1;
    chk("iss4_full", {31'h0, issue_ready}, 32'h0);
    post();
    // Issue and write together: allowed, count unchanged
    @(negedge clk); idle(); iss(3'd4); wr(4'd4, 32'h44);
    #1;
    chk("iss4_dec_ready", {31'h0, issue_ready}, 32'h1);
    post();
    @(negedge clk); idle(); issue_dest = 3'd4;
    #1;
    chk("iss4_still_full", {31'h0, issue_ready}, 32'h0);
    // Drain: count 3 -> 0, hazard visible until the last write
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle(); rd_addr0 = 3'd4; wr(4'd4, 32'h40 + 32'(k));
      #1;
      chk($sformatf("drain4_hazard_%0d", k), {31'h0, hazard},
          (k == 2 && FWD) ? 32'h0 : 32'h1);
      post();
    end
    @(negedge clk); idle(); rd_addr0 = 3'd4;
    #1;
    chk("drain4_done", {31'h0, hazard}, 32'h0);
    post();
    chk("drain4_data", rd_data0, 32'h42);

    // Backpressure alone stalls; writes still land
    @(negedge clk); idle(); wb_backpressure = 1'b0; wr(4'd1, 32'h77);
    #1;
    chk("bp_hazard", {31'h0, hazard}, 32'h0);
    chk("bp_stall", {31'h0, stall}, 32'h1);
    post();
    @(negedge clk); idle(); rd_addr1 = 3'd1;
    #1;
    chk("bp_off_stall", {31'h0, stall}, 32'h0);
    post();
    chk("bp_write_landed", rd_data1, 32'h77);

    // Flush overrides a concurrent issue; write in flush cycle still lands
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle(); iss(3'd6);
      post();
    end
    @(negedge clk); idle(); iss(3'd6); flush = 1'b1; rd_addr0 = 3'd6; wr(4'd6, 32'h66);
    #1;
    chk("flush_cycle_hazard", {31'h0, hazard}, 32'h1);
    post();
    @(negedge clk); idle(); rd_addr0 = 3'd6; issue_dest = 3'd6;
    #1;
    chk("flush_hazard6", {31'h0, hazard}, 32'h0);
    chk("flush_ready6", {31'h0, issue_ready}, 32'h1);
    post();
    chk("flush_write6", rd_data0, 32'h66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Architectural register file sitting at the consuming end of the write-back interface. It accepts one (destination, result) write per cycle from the write-back stage and serves two registered read ports to the read stage. A per-register pending-write scoreboard tracks in-flight destinations so the read stage can stall on RAW hazards. The write-back backpressure flag is folded into a single stall output.

Parameters:
D_SIZE, 32, data/result width in bits
REG_A_SIZE, 3, register address width; file holds 2**REG_A_SIZE registers
PEND_W, 2, width of each per-register pending-write counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
wb_destination  in  REG_A_SIZE+1  write-back destination; MSB=1 (out-of-bound register) means no write
wb_result  in  D_SIZE  write-back data
wb_backpressure  in  1  write-back backpressure; 0 = write-back is stalled, 1 = flowing
rd_addr0  in  REG_A_SIZE  read port 0 address
rd_addr1  in  REG_A_SIZE  read port 1 address
rd_data0  out  D_SIZE  read port 0 data, registered
rd_data1  out  D_SIZE  read port 1 data, registered
issue_valid  in  1  read stage issues an instruction that will write issue_dest
issue_dest  in  REG_A_SIZE  destination of the issued instruction
issue_ready  out  1  pending counter of issue_dest is not saturated
flush  in  1  synchronous clear of all pending counters
hazard  out  1  rd_addr0 or rd_addr1 has an unresolved pending write
stall  out  1  hazard OR NOT wb_backpressure

Behaviour:
- Reset (rst=1, async): all registers=0, all pending counters=0, rd_data0/1=0. Combinational outputs then give hazard=0, issue_ready=1, and stall = NOT wb_backpressure.
- Write: on posedge, if wb_destination MSB=0, regs[wb_destination[REG_A_SIZE-1:0]] <= wb_result. Writes are never refused, including while wb_backpressure=0.
- Read: rd_dataN <= regs[rd_addrN] on posedge (1-cycle latency). Same-cycle write to the same address returns wb_result (write-through; see optional feature).
- Scoreboard, per register r, next-state rules:
  - inc = issue_valid & issue_ready & issue_dest==r
  - dec = valid write to r & pending[r]!=0
  - inc & dec: pending[r] unchanged.
  - inc only: +1.
  - dec only: -1.
  - A write to r when pending[r]==0 (untracked) does not change the counter and never underflows.
- issue_ready: combinational; 0 when pending[issue_dest]==2**PEND_W-1 and no decrement of issue_dest occurs this cycle. If issue_valid is asserted while issue_ready=0, the issue is ignored and the counter is unchanged.
- hazard: combinational. For each read port, the port is hazardous if pending[rd_addrN]!=0, except when the pending count is 1 and a valid write to rd_addrN completes this cycle (bypassed). hazard = OR of both ports.
- flush: on posedge, all counters <= 0. Flush overrides a simultaneous inc/dec. Register contents are unaffected. A write completing in the flush cycle still updates the register.
- Register 0 is an ordinary register; there is no hardwired zero.

Optional Feature:
REGFILE_FORWARD_EN
- Defined: same-cycle write-through on both read ports, and hazard is suppressed for the completing register as described in Behaviour.
- Undefined: reads return the pre-write register value. Hazard stays asserted during the write cycle and clears only once the counter is 0 in the following cycle.

Test Plan:
- Assert rst mid-run after writing regs[3]=0xDEAD, then read 3 -> rd_data0=0, hazard=0, issue_ready=1, all counters 0.
- Write dest=5 / 0x1234; next cycle read rd_addr1=5 -> rd_data1=0x1234 one cycle later. Write with dest=8 (MSB set) -> no register changes.
- Issue dest=2; read 2 -> hazard=1, stall=1. Write-back dest=2 / 0xAA with rd_addr0=2 in the same cycle -> with forwarding hazard=0 and rd_data0=0xAA next cycle; without forwarding hazard=1 that cycle and rd_data0=old value.
- Issue dest=4 three times -> issue_ready=0; a fourth issue is ignored (count stays 3). Issue and write dest=4 in the same cycle -> count stays 3.
- With wb_backpressure=0 and no pending writes -> hazard=0, stall=1. A concurrent write dest=1 / 0x77 still lands in regs[1].
- Issue dest=6 twice, then flush together with issue dest=6 -> pending[6]=0, hazard on reading 6 is 0 the next cycle.
